// File: rtl/mf_clken_nco.sv
// -----------------------------------------------------------------------------
// mf_clken_nco
//
// Multi-channel, runtime-reconfigurable clock-enable generator running from a
// single reference clock. Each channel owns a fractional phase accumulator
// (NCO) whose overflow produces a one-cycle enable strobe at
// f_refclk * inc / 2^ACC_W. A shadow configuration is written through a
// valid/ready port and only takes effect on a commit pulse. A commit reloads
// every channel in the same cycle, so the per-channel phase offsets are exact.
// After the reload, a PLL-like settle period runs before locked asserts and the
// strobes are released.
//
// Parameters:
//   NUM_CH       number of enable channels (1..16)
//   ACC_W        accumulator / frequency word width (8..48)
//   LOCK_CYCLES  refclk cycles spent in SETTLE before locked (>= 1)
//
// Ports:
//   refclk     sole clock
//   rst        asynchronous, active-high reset
//   cfg_valid  config write request
//   cfg_ready  config write accepted when cfg_valid & cfg_ready (1 outside reset)
//   cfg_ch     target channel of the write; out-of-range indices are dropped
//   cfg_inc    frequency word for the shadow config
//   cfg_phase  accumulator preload (phase offset) for the shadow config
//   commit     one-cycle pulse: apply the shadow config and restart in phase
//   clken      per-channel one-cycle enable strobes, gated until locked
//   clk_level  per-channel square wave (accumulator MSB), see macro below
//   locked     channels running and aligned
//   busy       high while loading or settling
//
// Build option:
//   MF_CLKEN_NCO_LEVEL_EN  when defined, clk_level is the registered
//                          accumulator MSB gated by locked. When undefined,
//                          clk_level is tied to 0 and no flops are built for it.
// -----------------------------------------------------------------------------
module mf_clken_nco #(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              commit,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] clk_level,
  output logic              locked,
  output logic              busy
);

  // The settle counter only has to reach LOCK_CYCLES-1.
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               locked_q, locked_d;
  logic               busy_q, busy_d;

  logic [ACC_W-1:0]   shadow_inc_q   [NUM_CH];
  logic [ACC_W-1:0]   shadow_inc_d   [NUM_CH];
  logic [ACC_W-1:0]   shadow_phase_q [NUM_CH];
  logic [ACC_W-1:0]   shadow_phase_d [NUM_CH];
  logic [ACC_W-1:0]   active_inc_q   [NUM_CH];
  logic [ACC_W-1:0]   active_inc_d   [NUM_CH];
  logic [ACC_W-1:0]   acc_q          [NUM_CH];
  logic [ACC_W-1:0]   acc_d          [NUM_CH];

  logic [ACC_W:0]     sum            [NUM_CH];
  logic [NUM_CH-1:0]  carry;
  logic [NUM_CH-1:0]  clken_q, clken_d;

  logic               cfg_fire;

  // Ready is simply "not in reset": the write port never back-pressures.
  assign cfg_ready = ~rst;
  assign cfg_fire  = cfg_valid & cfg_ready;

  // ---------------------------------------------------------------------------
  // Shadow configuration. A write landing in the commit cycle is registered at
  // the same edge that moves the FSM to LOAD, so LOAD always sees it.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    shadow_inc_d   = shadow_inc_q;
    shadow_phase_d = shadow_phase_q;
    if (cfg_fire) begin
      // Matching each index explicitly drops out-of-range channels silently.
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ch == 4'(i)) begin
          shadow_inc_d[i]   = cfg_inc;
          shadow_phase_d[i] = cfg_phase;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM: IDLE -> LOAD -> SETTLE (LOCK_CYCLES) -> LOCKED.
  // A commit in SETTLE or LOCKED restarts from LOAD; LOAD itself is a fixed
  // single cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (commit) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (commit) begin
          state_d = ST_LOAD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOCKED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (commit) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    locked_d = (state_d == ST_LOCKED);
    busy_d   = (state_d == ST_LOAD) || (state_d == ST_SETTLE);
  end

  // ---------------------------------------------------------------------------
  // Phase accumulators. The sum is formed one bit wider so the top bit is the
  // overflow carry; the lower ACC_W bits wrap naturally, so there is no drift.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, active_inc_q[i]};
    end
  end

  always_comb begin
    active_inc_d = active_inc_q;
    acc_d        = acc_q;
    carry        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (state_q)
        ST_LOAD: begin
          // All channels reload in the same cycle: relative phase is exact.
          active_inc_d[i] = shadow_inc_q[i];
          acc_d[i]        = shadow_phase_q[i];
        end
        ST_SETTLE, ST_LOCKED: begin
          acc_d[i] = sum[i][ACC_W-1:0];
          carry[i] = sum[i][ACC_W];
        end
        default: ;  // IDLE: accumulators stay frozen at their reset value
      endcase
    end
    // Strobes are gated with the registered lock status of the cycle in
    // which they appear, so nothing leaks out during SETTLE or after commit.
    clken_d = carry & {NUM_CH{locked_d}};
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      clken_q  <= '0;
      // NOTE: the shadow/active arrays are small register files, not RAM, and
      // must come up at zero, so they are reset along with the control flops.
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_inc_q[i]   <= '0;
        shadow_phase_q[i] <= '0;
        active_inc_q[i]   <= '0;
        acc_q[i]          <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      locked_q       <= locked_d;
      busy_q         <= busy_d;
      clken_q        <= clken_d;
      shadow_inc_q   <= shadow_inc_d;
      shadow_phase_q <= shadow_phase_d;
      active_inc_q   <= active_inc_d;
      acc_q          <= acc_d;
    end
  end

  assign clken  = clken_q;
  assign locked = locked_q;
  assign busy   = busy_q;

  // ---------------------------------------------------------------------------
  // Optional square-wave output from the accumulator MSB.
  // ---------------------------------------------------------------------------
`ifdef MF_CLKEN_NCO_LEVEL_EN
  logic [NUM_CH-1:0] level_q, level_d;

  always_comb begin
    level_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      level_d[i] = acc_d[i][ACC_W-1] & locked_d;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign clk_level = level_q;
`else
  assign clk_level = '0;
`endif

endmodule

// File: doc/mf_clken_nco.md
Name: mf_clken_nco

Overview:
- Multi-channel, runtime-reconfigurable clock-enable generator. It is the fabric-side successor to the fixed-ratio core clock PLL.
- Runs from the single reference clock. Each channel has a fractional phase accumulator (NCO) that emits single-cycle enables at an arbitrary ratio of refclk, e.g. 3.276 MHz or 13.104 MHz strobes from 74.25 MHz.
- Per-channel phase offsets give quadrature/shifted strobes.
- Provides PLL-like lock/settle sequencing, so downstream logic can swap PLL outputs for enables.

Parameters:
NUM_CH, 3, number of enable channels (1..16)
ACC_W, 32, accumulator/increment width in bits (8..48)
LOCK_CYCLES, 1024, refclk cycles spent in SETTLE before locked asserts (>=1)

Ports:
refclk  input  1  sole clock
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  config write request
cfg_ready  output  1  config write accepted when valid&ready
cfg_ch  input  4  target channel index
cfg_inc  input  ACC_W  frequency word; f_out = f_refclk*inc/2^ACC_W
cfg_phase  input  ACC_W  accumulator preload (phase offset, fraction of one period)
commit  input  1  single-cycle pulse: apply shadow config and restart all channels in phase
clken  output  NUM_CH  per-channel one-cycle enable strobes
clk_level  output  NUM_CH  per-channel square wave (see Optional Feature)
locked  output  1  channels running and aligned
busy  output  1  high in LOAD or SETTLE

Behaviour:
- Reset (async assert, sync use after deassert):
  - acc, shadow inc, shadow phase, active inc = 0.
  - state = IDLE.
  - clken, clk_level, locked, busy = 0.
  - cfg_ready = 0 while rst is high, 1 otherwise.
- Config write:
  - Accepted on the cycle cfg_valid & cfg_ready; cfg_ready is 1 in every state after reset.
  - Writes shadow_inc[cfg_ch] and shadow_phase[cfg_ch] only; running channels are unaffected until commit.
  - If cfg_ch >= NUM_CH: handshake completes, no register changes.
  - A write and a commit in the same cycle: the write lands first, and commit uses the new value.
- States:
  - IDLE: accumulators frozen at 0, clken = 0. On commit -> LOAD.
  - LOAD (1 cycle): active_inc <= shadow_inc; acc <= shadow_phase for all channels; locked <= 0; -> SETTLE.
  - SETTLE: accumulators run; clken outputs gated to 0; a counter counts LOCK_CYCLES cycles, then -> LOCKED.
  - LOCKED: locked = 1; clken ungated.
  - Commit in SETTLE or LOCKED -> LOAD. locked falls on the cycle after commit, and the settle counter restarts.
- Accumulator, per channel, every cycle outside IDLE/LOAD:
  - {carry, acc} <= acc + active_inc, computed at ACC_W+1 bits; the sum wraps modulo 2^ACC_W.
  - clken[i] is carry registered: one cycle latency from overflow, high for exactly one cycle, gated by locked.
- Ratio edge cases:
  - inc = 0: channel never strobes.
  - inc >= 2^(ACC_W-1): strobes on most cycles; max rate is every cycle only as inc approaches 2^ACC_W.
  - Long-run strobe count over N cycles = floor((phase + N*inc)/2^ACC_W), with no drift.
- Phase alignment: all channels load in the same LOAD cycle, so the relative phase between channels equals (phase_a - phase_b)/2^ACC_W of a period, independent of settle time.
- Reset mid-operation returns immediately to reset values; the shadow config is lost.

Optional Feature:
- Macro MF_CLKEN_NCO_LEVEL_EN.
- Defined: clk_level[i] = registered acc[i] MSB, gated to 0 when not locked. This gives roughly 50% duty with jitter of one refclk period.
- Not defined: clk_level is tied to 0 and no extra flops are inferred. All other behaviour is identical.

Test Plan:
- ACC_W=8, LOCK_CYCLES=4; reset; write ch0 inc=0x40 phase=0; commit:
  - busy high for 5 cycles (LOAD + 4 SETTLE);
  - locked rises at cycle 6;
  - then clken[0] pulses every 4 cycles, one cycle wide.
- Same setup, ch1 inc=0x40 phase=0x80, ch2 inc=0x00:
  - clken[1] pulses exactly 2 cycles offset from clken[0];
  - clken[2] stays 0.
- ACC_W=8, inc=0x03 run for 256 cycles after lock -> exactly 3 clken pulses on ch0, with period variation limited to 85/86 cycles.
- Commit while LOCKED with new ch0 inc=0x80:
  - locked falls the next cycle; clken is suppressed during SETTLE;
  - after relock, clken[0] pulses every 2 cycles.
- Write with cfg_ch=15 (NUM_CH=3) -> cfg_ready handshake completes; after commit, all channel periods are unchanged.
- Assert rst mid-SETTLE -> locked, busy, clken all 0 asynchronously; after release, state is IDLE and no pulses occur without a new commit.
